// File: rtl/mem_stage.sv
`default_nettype none
// mem_stage: LoongArch MEM pipeline stage. Collects data-SRAM responses,
// extracts/extends load data and forwards results to WB and ID. Rev 1.0
module mem_stage #(
  parameter int EXPT_WD         = 98,
  parameter int ES_TO_MS_BUS_WD = EXPT_WD + 78,
  parameter int MS_TO_WS_BUS_WD = EXPT_WD + 70
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_allowin,
  input  logic                       data_req_hs,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata,
  input  logic                       ws_allowin,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [38:0]                ms_fw_bus,
  input  logic                       expt_clear
);

  localparam int ALU_LSB  = 0;
  localparam int DEST_LSB = 32;
  localparam int GRWE_BIT = 37;
  localparam int PC_LSB   = 38;
  localparam int ADDR_LSB = 70;
  localparam int MREQ_BIT = 72;
  localparam int LDOP_LSB = 73;
  localparam int EXPT_LSB = 78;

  // ld_op one-hot bit positions, MSB first: ld.b, ld.h, ld.w, ld.bu, ld.hu
  localparam int LD_B_BIT  = 4;
  localparam int LD_H_BIT  = 3;
  localparam int LD_W_BIT  = 2;
  localparam int LD_BU_BIT = 1;
  localparam int LD_HU_BIT = 0;

  logic                       r_ms_valid;
  logic [ES_TO_MS_BUS_WD-1:0] r_payload;
  logic [1:0]                 r_outstanding;
  logic [1:0]                 r_discard_cnt;
  logic                       r_rbuf_valid;
  logic [31:0]                r_rbuf;

  logic [EXPT_WD-1:0] w_expt;
  logic [4:0]         w_ld_op;
  logic               w_mem_req;
  logic [1:0]         w_addr_lo;
  logic [31:0]        w_pc;
  logic               w_gr_we;
  logic [4:0]         w_dest;
  logic [31:0]        w_alu_result;

  assign w_expt       = r_payload[EXPT_LSB +: EXPT_WD];
  assign w_ld_op      = r_payload[LDOP_LSB +: 5];
  assign w_mem_req    = r_payload[MREQ_BIT];
  assign w_addr_lo    = r_payload[ADDR_LSB +: 2];
  assign w_pc         = r_payload[PC_LSB +: 32];
  assign w_gr_we      = r_payload[GRWE_BIT];
  assign w_dest       = r_payload[DEST_LSB +: 5];
  assign w_alu_result = r_payload[ALU_LSB +: 32];

  logic       w_resp_live;
  logic       w_ready_go;
  logic       w_accept;
  logic       w_leave;
  logic [1:0] w_outstanding_next;

  // A response is live only when no flushed response is still owed.
  assign w_resp_live    = data_sram_data_ok & (r_discard_cnt == 2'd0);
  assign w_ready_go     = ~w_mem_req | r_rbuf_valid | w_resp_live;
  assign ms_allowin     = ~r_ms_valid | (w_ready_go & ws_allowin);
  assign ms_to_ws_valid = r_ms_valid & w_ready_go & ~expt_clear;
  assign w_accept       = ms_allowin & es_to_ms_valid;
  assign w_leave        = ms_to_ws_valid & ws_allowin;

  assign w_outstanding_next = r_outstanding + {1'b0, data_req_hs}
                            - {1'b0, data_sram_data_ok};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ms_valid <= 1'b0;
    end else if (expt_clear) begin
      r_ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      r_ms_valid <= es_to_ms_valid;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_payload <= '0;
    end else if (w_accept) begin
      r_payload <= es_to_ms_bus;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_outstanding <= 2'd0;
    end else begin
      r_outstanding <= w_outstanding_next;
    end
  end

  // On a flush every in-flight response belongs to a killed instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_discard_cnt <= 2'd0;
    end else if (expt_clear) begin
      r_discard_cnt <= w_outstanding_next;
    end else if (data_sram_data_ok && (r_discard_cnt != 2'd0)) begin
      r_discard_cnt <= r_discard_cnt - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rbuf_valid <= 1'b0;
      r_rbuf       <= 32'd0;
    end else if (expt_clear || w_leave) begin
      r_rbuf_valid <= 1'b0;
    end else if (w_resp_live && r_ms_valid && w_mem_req && !r_rbuf_valid) begin
      r_rbuf_valid <= 1'b1;
      r_rbuf       <= data_sram_rdata;
    end
  end

  logic [31:0] w_rdata_sel;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_final_result;
  logic        w_is_load;

  assign w_rdata_sel = r_rbuf_valid ? r_rbuf : data_sram_rdata;
  assign w_half      = w_addr_lo[1] ? w_rdata_sel[31:16] : w_rdata_sel[15:0];
  assign w_is_load   = w_mem_req & (|w_ld_op);

  always_comb begin
    w_byte = w_rdata_sel[7:0];
    case (w_addr_lo)
      2'd0:    w_byte = w_rdata_sel[7:0];
      2'd1:    w_byte = w_rdata_sel[15:8];
      2'd2:    w_byte = w_rdata_sel[23:16];
      default: w_byte = w_rdata_sel[31:24];
    endcase
  end

  always_comb begin
    w_load_data = w_rdata_sel;
    if (w_ld_op[LD_B_BIT]) begin
      w_load_data = {{24{w_byte[7]}}, w_byte};
    end else if (w_ld_op[LD_BU_BIT]) begin
      w_load_data = {24'd0, w_byte};
    end else if (w_ld_op[LD_H_BIT]) begin
      w_load_data = {{16{w_half[15]}}, w_half};
    end else if (w_ld_op[LD_HU_BIT]) begin
      w_load_data = {16'd0, w_half};
    end else if (w_ld_op[LD_W_BIT]) begin
      w_load_data = w_rdata_sel;
    end
  end

  assign w_final_result = w_is_load ? w_load_data : w_alu_result;

  logic w_load_pending;
  assign w_load_pending = r_ms_valid & w_is_load & ~w_ready_go;

  assign ms_to_ws_bus = {w_expt, w_pc, w_gr_we, w_dest, w_final_result};
  assign ms_fw_bus    = {w_load_pending, r_ms_valid & w_gr_we, w_dest, w_final_result};

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// tb_mem_stage: randomized EX/SRAM/WB environment with a scoreboard model of
// in-order instruction results, flushes and response ownership.
module tb_mem_stage;
  localparam int EXPT_WD = 98;
  localparam int ES_WD   = EXPT_WD + 78;
  localparam int MS_WD   = EXPT_WD + 70;
  localparam logic [4:0] LD_B  = 5'b10000;
  localparam logic [4:0] LD_H  = 5'b01000;
  localparam logic [4:0] LD_W  = 5'b00100;
  localparam logic [4:0] LD_BU = 5'b00010;
  localparam logic [4:0] LD_HU = 5'b00001;

  logic             clk = 1'b0;
  logic             reset;
  logic             es_to_ms_valid;
  logic [ES_WD-1:0] es_to_ms_bus;
  logic             ms_allowin;
  logic             data_req_hs;
  logic             data_sram_data_ok;
  logic [31:0]      data_sram_rdata;
  logic             ws_allowin;
  logic             ms_to_ws_valid;
  logic [MS_WD-1:0] ms_to_ws_bus;
  logic [38:0]      ms_fw_bus;
  logic             expt_clear;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset), .es_to_ms_valid(es_to_ms_valid), .es_to_ms_bus(es_to_ms_bus),
    .ms_allowin(ms_allowin), .data_req_hs(data_req_hs), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata), .ws_allowin(ws_allowin), .ms_to_ws_valid(ms_to_ws_valid),
    .ms_to_ws_bus(ms_to_ws_bus), .ms_fw_bus(ms_fw_bus), .expt_clear(expt_clear)
  );

  typedef struct {
    int                 id;
    logic [EXPT_WD-1:0] expt;
    logic [31:0]        pc;
    logic               gr_we;
    logic [4:0]         dest;
    logic               mem;
    logic [4:0]         ld_op;
    logic [31:0]        result;
    bit                 in_mem;
    bit                 arrived;
  } sb_t;
  typedef struct { int id; logic [31:0] data; int lat; } rq_t;
  typedef struct { logic mem; logic [4:0] op; logic [31:0] alu; logic [31:0] rdata; int lat; } dir_t;

  sb_t sb[$];
  rq_t sram_q[$];
  dir_t dirs[5];
  int tests = 0;
  int fails = 0;
  int next_id = 0;
  int dir_idx = 0;

  task automatic chk(input string name, input logic [MS_WD-1:0] act, input logic [MS_WD-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Architectural load semantics: select by address, then extend.
  function automatic logic [31:0] ref_result(input logic mem, input logic [4:0] op,
                                              input logic [31:0] addr, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] sb_w;
    logic [31:0] sh_w;
    sb_w = rdata >> (int'(addr[1:0]) * 8);
    sh_w = rdata >> (int'(addr[1]) * 16);
    b = sb_w[7:0];
    h = sh_w[15:0];
    if (!mem || op == 5'd0) return addr;
    case (op)
      LD_B:    return {{24{b[7]}}, b};
      LD_BU:   return {24'd0, b};
      LD_H:    return {{16{h[15]}}, h};
      LD_HU:   return {16'd0, h};
      default: return rdata;
    endcase
  endfunction

  task automatic drive_cycle(input bit allow_issue);
    sb_t t;
    rq_t r;
    bit slots_ok, offer, directed;
    logic mem;
    logic [4:0] op;
    logic [31:0] alu, rdata, pc;
    logic [4:0] dest;
    logic gr_we;
    logic [127:0] rnd;
    int lat, kind;
    logic [4:0] ops[5];
    ops = '{LD_B, LD_H, LD_W, LD_BU, LD_HU};
    slots_ok = (sram_q.size() <= 1);
    for (int i = 0; i < sb.size(); i++) begin
      t = sb[i]; t.in_mem = 1'b1; sb[i] = t;
    end
    data_sram_data_ok = 1'b0;
    data_sram_rdata   = $urandom;
    if (sram_q.size() > 0) begin
      r = sram_q[0];
      if (r.lat <= 1) begin
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = r.data;
        void'(sram_q.pop_front());
        for (int i = 0; i < sb.size(); i++) begin
          if (sb[i].id == r.id) begin
            t = sb[i]; t.arrived = 1'b1; sb[i] = t;
          end
        end
      end else begin
        r.lat--;
        sram_q[0] = r;
      end
    end
    directed   = allow_issue && (dir_idx < 5);
    ws_allowin = ($urandom_range(0, 3) != 0);
    expt_clear = allow_issue && !directed && ($urandom_range(0, 15) == 0);
    rnd   = {$urandom, $urandom, $urandom, $urandom};
    pc    = $urandom;
    dest  = 5'($urandom_range(0, 31));
    gr_we = 1'($urandom_range(0, 1));
    if (directed) begin
      mem = dirs[dir_idx].mem; op = dirs[dir_idx].op; alu = dirs[dir_idx].alu;
      rdata = dirs[dir_idx].rdata; lat = dirs[dir_idx].lat;
      offer = !mem || slots_ok;
    end else begin
      kind  = $urandom_range(0, 6);
      mem   = (kind <= 5) && slots_ok;
      op    = (kind <= 4) ? ops[kind] : 5'd0;
      if (!mem) op = 5'd0;
      alu   = $urandom;
      rdata = $urandom;
      lat   = $urandom_range(1, 4);
      offer = allow_issue && ($urandom_range(0, 3) != 0);
    end
    es_to_ms_valid = offer;
    es_to_ms_bus   = {rnd[EXPT_WD-1:0], op, mem, alu[1:0], pc, gr_we, dest, alu};
    data_req_hs    = 1'b0;
    #1;
    if (offer && ms_allowin) begin
      if (mem) begin
        data_req_hs = 1'b1;
        sram_q.push_back('{id: next_id, data: rdata, lat: lat});
      end
      if (!expt_clear) begin
        sb.push_back('{id: next_id, expt: rnd[EXPT_WD-1:0], pc: pc, gr_we: gr_we, dest: dest,
                       mem: mem, ld_op: op, result: ref_result(mem, op, alu, rdata),
                       in_mem: 1'b0, arrived: 1'b0});
      end
      next_id++;
      if (directed) dir_idx++;
    end
  endtask

  // Monitor: checks handshake outputs every cycle, pops on each WB transfer.
  initial begin
    sb_t e;
    bit has, ready, exp_valid, exp_allow, exp_pend;
    forever begin
      @(negedge clk);
      #3;
      has = 1'b0;
      if (sb.size() > 0) begin
        e = sb[0];
        has = e.in_mem;
      end
      ready     = has && (!e.mem || e.arrived);
      exp_valid = ready && !expt_clear;
      exp_allow = !has || (ready && ws_allowin);
      exp_pend  = has && e.mem && (e.ld_op != 5'd0) && !ready;
      chk("ms_to_ws_valid", MS_WD'(ms_to_ws_valid), MS_WD'(exp_valid));
      chk("ms_allowin", MS_WD'(ms_allowin), MS_WD'(exp_allow));
      chk("load_pending", MS_WD'(ms_fw_bus[38]), MS_WD'(exp_pend));
      chk("fw_we", MS_WD'(ms_fw_bus[37]), MS_WD'(has && e.gr_we));
      if (reset) begin
        chk("reset_bus", ms_to_ws_bus, '0);
        chk("reset_fw", MS_WD'(ms_fw_bus), '0);
      end
      if (has) chk("fw_dest", MS_WD'(ms_fw_bus[36:32]), MS_WD'(e.dest));
      if (exp_valid && ws_allowin) begin
        chk("wb_bus", ms_to_ws_bus, {e.expt, e.pc, e.gr_we, e.dest, e.result});
        chk("fw_result", MS_WD'(ms_fw_bus[31:0]), MS_WD'(e.result));
        void'(sb.pop_front());
      end
      if (expt_clear) sb.delete();
    end
  end

  initial begin
    bit did_reset = 1'b0;
    dirs[0] = '{mem: 1'b1, op: LD_B,  alu: 32'h0000_1003, rdata: 32'h8011_2233, lat: 1};
    dirs[1] = '{mem: 1'b1, op: LD_HU, alu: 32'h0000_2002, rdata: 32'hBEEF_1234, lat: 2};
    dirs[2] = '{mem: 1'b0, op: 5'd0,  alu: 32'h1234_5678, rdata: 32'h0,         lat: 1};
    dirs[3] = '{mem: 1'b1, op: 5'd0,  alu: 32'h0000_4000, rdata: 32'h5555_5555, lat: 4};
    dirs[4] = '{mem: 1'b1, op: LD_W,  alu: 32'h0000_5000, rdata: 32'hCCCC_0001, lat: 1};
    reset = 1'b1; es_to_ms_valid = 1'b0; es_to_ms_bus = '0; data_req_hs = 1'b0;
    data_sram_data_ok = 1'b0; data_sram_rdata = '0; ws_allowin = 1'b1; expt_clear = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      reset = 1'b0;
      if (!did_reset && c > 200 && sb.size() > 0 && sram_q.size() > 0
          && sb[0].mem && !sb[0].arrived) begin
        did_reset = 1'b1;
        es_to_ms_valid = 1'b0; data_req_hs = 1'b0; data_sram_data_ok = 1'b0;
        expt_clear = 1'b0; ws_allowin = 1'b1;
        #2;
        reset = 1'b1;
        sb.delete();
        sram_q.delete();
        #2;
        chk("async_rst_valid", MS_WD'(ms_to_ws_valid), '0);
        chk("async_rst_allowin", MS_WD'(ms_allowin), MS_WD'(1));
        chk("async_rst_fw", MS_WD'(ms_fw_bus), '0);
      end else begin
        drive_cycle(1'b1);
      end
    end
    for (int c = 0; c < 300 && (sb.size() > 0 || sram_q.size() > 0); c++) begin
      @(negedge clk);
      drive_cycle(1'b0);
    end
    @(negedge clk);
    tests++;
    if (sb.size() > 0 || sram_q.size() > 0) begin
      fails++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size() + sram_q.size());
    end
    tests++;
    if (!did_reset) begin
      fails++;
      $display("FAIL async_reset_scenario: got 0 occurrences expected 1");
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
